lane_seg_mul_scale_pipe: RTL and testbench



---
 rtl/lane_seg_mul_scale_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_lane_seg_mul_scale_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_seg_mul_scale_pipe.sv
// -----------------------------------------------------------------------------
// lane_seg_mul_scale_pipe
//
// Pipelined signed x unsigned multiplier with rounding right-shift and
// saturation to a signed result. Used to scale lane_seg feature values by a
// coefficient between dataflow stages. Flow control is a valid/ready pipeline
// that collapses bubbles: each stage refills as soon as it or any stage
// downstream of it is empty.
//
// Stage 1 registers the full-width product. Middle stages carry that product
// unchanged. The last stage registers the rounded, saturated result. With
// NUM_STAGE = 1 the single register does all three steps.
//
// Ports:
//   ap_clk      clock, rising edge
//   ap_rst      synchronous active-high reset; drops all in-flight beats
//   din_valid   input beat valid
//   din_ready   block accepts a beat this cycle (combinational from
//               dout_ready and the stage valid bits only)
//   din0        signed operand, din0_WIDTH bits
//   din1        unsigned operand, din1_WIDTH bits, zero-extended
//   dout_valid  output beat valid
//   dout_ready  downstream accepts
//   dout        rounded, saturated result, dout_WIDTH bits, signed
//   dout_sat    qualifies dout: result was clipped to min or max
//   sat_cnt     (LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN only) count of
//               transferred output beats with dout_sat = 1; stops at 0xFFFF
//
// Optional feature macro: LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
// -----------------------------------------------------------------------------
module lane_seg_mul_scale_pipe #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 11,
   parameter int SHIFT      = 8,
   parameter int dout_WIDTH = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [dout_WIDTH-1:0] dout,
`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
   output logic [15:0]           sat_cnt,
`endif
   output logic                  dout_sat
);

   // Product width: exact for a signed din0 times a zero-extended din1.
   localparam int P  = din0_WIDTH + din1_WIDTH;
   // Rounding/compare width: one guard bit above the product, and wide enough
   // to hold the saturation limits even when dout is wider than the product.
   localparam int RW = (P + 1 > dout_WIDTH + 1) ? P + 1 : dout_WIDTH + 1;

   // Half an LSB of the shifted result; zero when SHIFT = 0.
   localparam logic signed [RW-1:0] RND   = (RW'(1) << SHIFT) >> 1;
   localparam logic signed [RW-1:0] R_MAX =
      $signed({{(RW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}});
   localparam logic signed [RW-1:0] R_MIN =
      $signed({{(RW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}});

   if (NUM_STAGE < 1 || NUM_STAGE > 8 || SHIFT < 0 || SHIFT > P - 1 || ID < 0) begin : g_bad_cfg
      $error("lane_seg_mul_scale_pipe: parameter out of legal range");
   end

   typedef struct packed {
      logic                  sat;
      logic [dout_WIDTH-1:0] val;
   } res_t;

   // Round half toward +inf, arithmetic shift, then clip to dout range.
   function automatic res_t round_sat(input logic signed [P-1:0] p);
      logic signed [RW-1:0] r;
      res_t                 res;
      res = '0;
      r   = (RW'(p) + RND) >>> SHIFT;
      if (r > R_MAX) begin
         res.sat = 1'b1;
         res.val = {1'b0, {(dout_WIDTH-1){1'b1}}};
      end else if (r < R_MIN) begin
         res.sat = 1'b1;
         res.val = {1'b1, {(dout_WIDTH-1){1'b0}}};
      end else begin
         res.val = dout_WIDTH'(r);
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- multiply
   logic signed [P-1:0] op0_ext;
   logic signed [P-1:0] op1_ext;
   logic signed [P-1:0] prod_in;

   assign op0_ext = P'($signed(din0));
   assign op1_ext = P'({1'b0, din1});
   assign prod_in = op0_ext * op1_ext;

   // ------------------------------------------------------------ flow control
   logic [NUM_STAGE-1:0] v_q;
   logic [NUM_STAGE-1:0] v_d;
   logic [NUM_STAGE-1:0] adv;

   // Stage s may advance when the output is taken or any stage from s to the
   // end holds a bubble. Written flat so no bit depends on another bit of adv.
   for (genvar s = 0; s < NUM_STAGE; s++) begin : g_adv
      assign adv[s] = dout_ready | ~(&v_q[NUM_STAGE-1:s]);
   end

   assign din_ready  = adv[0];
   assign dout_valid = v_q[NUM_STAGE-1];

   // NOTE: every always_comb output gets a default before any conditional
   // update, so no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      v_d = v_q;
      if (adv[0]) v_d[0] = din_valid;
      for (int s = 1; s < NUM_STAGE; s++) begin
         if (adv[s]) v_d[s] = v_q[s-1];
      end
   end

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of the others.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) v_q <= '0;
      else        v_q <= v_d;
   end

   // ---------------------------------------------------------- product stages
   logic signed [P-1:0] fin_src;
   logic                fin_load;

   if (NUM_STAGE > 1) begin : g_prod
      logic signed [P-1:0] prod_q [NUM_STAGE-1];
      logic signed [P-1:0] prod_d [NUM_STAGE-1];

      // Data moves only with a valid beat, so idle inputs never disturb state.
      always_comb begin
         prod_d = prod_q;
         if (adv[0] && din_valid) prod_d[0] = prod_in;
         for (int s = 1; s < NUM_STAGE - 1; s++) begin
            if (adv[s] && v_q[s-1]) prod_d[s] = prod_q[s-1];
         end
      end

      // NOTE: data registers are reset as well as valid bits so that dout
      // reads zero after reset; this is a handful of flops, not a RAM.
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            for (int s = 0; s < NUM_STAGE - 1; s++) prod_q[s] <= '0;
         end else begin
            prod_q <= prod_d;
         end
      end

      assign fin_src  = prod_q[NUM_STAGE-2];
      assign fin_load = adv[NUM_STAGE-1] & v_q[NUM_STAGE-2];
   end else begin : g_single
      assign fin_src  = prod_in;
      assign fin_load = adv[0] & din_valid;
   end

   // -------------------------------------------------------------- last stage
   res_t res_q;
   res_t res_d;

   always_comb begin
      res_d = res_q;
      if (fin_load) res_d = round_sat(fin_src);
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) res_q <= '0;
      else        res_q <= res_d;
   end

   assign dout     = res_q.val;
   assign dout_sat = res_q.sat;

`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
   // ------------------------------------------------------ saturation counter
   logic [15:0] sat_cnt_q;
   logic [15:0] sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (dout_valid && dout_ready && res_q.sat && (sat_cnt_q != 16'hFFFF))
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) sat_cnt_q <= '0;
      else        sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_lane_seg_mul_scale_pipe.sv
// -----------------------------------------------------------------------------
// Bench for lane_seg_mul_scale_pipe.
// u_dut: default configuration (3 stages, 16x11, shift 8, 16-bit result).
// u_one: single stage, no shift, 27-bit result.
// Expected results come from a longint reference model; a queue holds them in
// issue order and a negedge monitor pops one per output transfer.
// -----------------------------------------------------------------------------
module tb_lane_seg_mul_scale_pipe;

   localparam int N_A = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        din_valid  = 1'b0;
   logic        dout_ready = 1'b1;
   logic [15:0] din0 = '0;
   logic [10:0] din1 = '0;
   logic        din_ready;
   logic        dout_valid;
   logic [15:0] dout;
   logic        dout_sat;

   logic        b_din_valid  = 1'b0;
   logic        b_dout_ready = 1'b1;
   logic [15:0] b_din0 = '0;
   logic [10:0] b_din1 = '0;
   logic        b_din_ready;
   logic        b_dout_valid;
   logic [26:0] b_dout;
   logic        b_dout_sat;

`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
   logic [15:0] sat_cnt;
   logic [15:0] b_sat_cnt;
`endif

   always #5 clk = ~clk;

   lane_seg_mul_scale_pipe #(
      .ID(1), .NUM_STAGE(N_A), .din0_WIDTH(16), .din1_WIDTH(11),
      .SHIFT(8), .dout_WIDTH(16)
   ) u_dut (
      .ap_clk     (clk),
      .ap_rst     (rst),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din0       (din0),
      .din1       (din1),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout),
`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
      .sat_cnt    (sat_cnt),
`endif
      .dout_sat   (dout_sat)
   );

   lane_seg_mul_scale_pipe #(
      .ID(2), .NUM_STAGE(1), .din0_WIDTH(16), .din1_WIDTH(11),
      .SHIFT(0), .dout_WIDTH(27)
   ) u_one (
      .ap_clk     (clk),
      .ap_rst     (rst),
      .din_valid  (b_din_valid),
      .din_ready  (b_din_ready),
      .din0       (b_din0),
      .din1       (b_din1),
      .dout_valid (b_dout_valid),
      .dout_ready (b_dout_ready),
      .dout       (b_dout),
`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
      .sat_cnt    (b_sat_cnt),
`endif
      .dout_sat   (b_dout_sat)
   );

   typedef struct {
      longint val;
      bit     sat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp    = 0;
   int   n_fail   = 0;
   int   n_out    = 0;
   int   inflight = 0;
   int   sat_pops = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer product, floor((p + half) / 2^sh), then clamp.
   function automatic exp_t model(input longint a, input longint b, input int sh, input int w);
      exp_t   e;
      longint p, r, mx, mn;
      p = a * b;
      if (sh > 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
      else        r = p;
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -(longint'(1) << (w - 1));
      if (r > mx)      begin e.val = mx; e.sat = 1'b1; end
      else if (r < mn) begin e.val = mn; e.sat = 1'b1; end
      else             begin e.val = r;  e.sat = 1'b0; end
      return e;
   endfunction

   function automatic logic [15:0] rnd_a();
      case ($urandom_range(0, 7))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [10:0] rnd_b();
      case ($urandom_range(0, 7))
         0:       return 11'h7FF;
         1:       return 11'h000;
         default: return 11'($urandom);
      endcase
   endfunction

   // Issue side: record accepted beats (pre-edge values) and occupancy.
   always @(posedge clk) begin
      if (rst) begin
         sb.delete();
         inflight = 0;
         sat_pops = 0;
      end else begin
         if (din_valid && din_ready) begin
            sb.push_back(model(longint'($signed(din0)), longint'(din1), 8, 16));
            inflight++;
         end
         if (dout_valid && dout_ready) inflight--;
      end
   end

   // Output side: ready rule, stall stability, in-order results.
   bit          hold_valid = 1'b0;
   logic [16:0] held;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (rst) begin
         hold_valid = 1'b0;
      end else begin
         check("din_ready_rule", din_ready, (dout_ready || inflight < N_A) ? 1 : 0);
         if (hold_valid) check("stall_hold", {dout_valid, dout_sat, dout}, {1'b1, held});
         if (dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL sb_unexpected: got beat %0d, expected no output", $signed(dout));
            end else begin
               mon_e = sb.pop_front();
               check("sb_val", longint'($signed(dout)), mon_e.val);
               check("sb_sat", dout_sat, mon_e.sat);
               n_out++;
               if (mon_e.sat) sat_pops++;
            end
         end
         hold_valid = dout_valid && !dout_ready;
         held       = {dout_sat, dout};
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One beat on an idle, unstalled pipe: checks latency and the value.
   task automatic send_timed(input string name, input logic [15:0] a, input logic [10:0] b,
                             input longint ev, input bit es);
      int lat;
      @(posedge clk); #1;
      din_valid = 1'b1; din0 = a; din1 = b;
      @(negedge clk);
      check({name, "_ready"}, din_ready, 1);
      @(posedge clk); #1;
      din_valid = 1'b0; din0 = 16'($urandom); din1 = 11'($urandom);
      lat = 1;
      @(negedge clk);
      while (!dout_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_lat"}, lat, N_A);
      check({name, "_val"}, longint'($signed(dout)), ev);
      check({name, "_sat"}, dout_sat, es);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int sent, k, gaps, n0;
      bit saw_low;

      // Reset, with junk presented on the inputs that must be ignored.
      rst = 1'b1;
      din_valid = 1'b1; din0 = 16'h1234; din1 = 11'h155;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_sat", dout_sat, 0);
      @(posedge clk); #1;
      rst = 1'b0; din_valid = 1'b0;
      @(negedge clk);
      check("rst_din_ready", din_ready, 1);
      check("rst_no_output", dout_valid, 0);

      // Directed arithmetic.
      send_timed("mul_1000x512", 16'd1000,  11'd512,  2000,   1'b0);
      send_timed("neg_round",    16'hFFFD,  11'd43,   -1,     1'b0);
      send_timed("half_up",      16'hFFFF,  11'd128,  0,      1'b0);
      send_timed("sat_max",      16'h7FFF,  11'd2047, 32767,  1'b1);
      send_timed("sat_min",      16'h8000,  11'd2047, -32768, 1'b1);
      idle(3);
`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
      @(negedge clk);
      check("sat_cnt_directed", sat_cnt, 2);
`endif

      // Backpressure: 10 beats, output stalled for cycles 4..9.
      n0 = n_out; sent = 0; k = 0; gaps = 0; saw_low = 1'b0;
      while ((sent < 10 || sb.size() > 0) && k < 60) begin
         @(posedge clk); #1;
         dout_ready = !(k >= 4 && k <= 9);
         din_valid  = (sent < 10);
         din0 = rnd_a(); din1 = rnd_b();
         @(negedge clk);
         if (din_valid && din_ready) sent++;
         if (!din_ready) saw_low = 1'b1;
         if (k >= 10 && !dout_valid && (sent < 10 || sb.size() > 0)) gaps++;
         k++;
      end
      @(posedge clk); #1;
      din_valid = 1'b0; dout_ready = 1'b1;
      check("bp_ready_dropped", saw_low, 1);
      check("bp_all_sent", sent, 10);
      check("bp_drained", sb.size(), 0);
      check("bp_out_count", n_out - n0, 10);
      check("bp_back_to_back", gaps, 0);

      // Random traffic with random backpressure and idle-cycle junk.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         din_valid  = ($urandom % 10) < 7;
         dout_ready = ($urandom % 10) < 7;
         din0 = rnd_a(); din1 = rnd_b();
      end
      @(posedge clk); #1;
      din_valid = 1'b0; dout_ready = 1'b1;
      k = 0;
      while (sb.size() > 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check("rnd_drained", sb.size(), 0);
`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
      check("sat_cnt_random", sat_cnt, (sat_pops > 65535) ? 65535 : sat_pops);
`endif

      // Reset with three beats held in a stalled pipe.
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         dout_ready = 1'b0; din_valid = 1'b1;
         din0 = rnd_a(); din1 = rnd_b();
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
      @(negedge clk);
      check("rst_ms_full_valid", dout_valid, 1);
      check("rst_ms_full_ready", din_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1; dout_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_ms_dout_valid", dout_valid, 0);
      check("rst_ms_dout", dout, 0);
      check("rst_ms_dout_sat", dout_sat, 0);
      check("rst_ms_din_ready", din_ready, 1);
`ifdef LANE_SEG_MUL_SCALE_PIPE_OVF_CNT_EN
      check("rst_ms_sat_cnt", sat_cnt, 0);
`endif
      n0 = n_out;
      idle(10);
      check("rst_ms_no_stale", n_out - n0, 0);

      // Single-stage, unshifted, 27-bit configuration.
      @(posedge clk); #1;
      b_din_valid = 1'b1; b_din0 = 16'h8000; b_din1 = 11'd2047;
      @(negedge clk);
      check("one_ready", b_din_ready, 1);
      check("one_idle_valid", b_dout_valid, 0);
      @(posedge clk); #1;
      b_din0 = 16'h7FFF; b_din1 = 11'd2047;
      @(negedge clk);
      check("one_lat1_valid", b_dout_valid, 1);
      check("one_min_val", longint'($signed(b_dout)), -67076096);
      check("one_min_sat", b_dout_sat, 0);
      @(posedge clk); #1;
      b_din_valid = 1'b0;
      @(negedge clk);
      check("one_max_valid", b_dout_valid, 1);
      check("one_max_val", longint'($signed(b_dout)), 67074049);
      check("one_max_sat", b_dout_sat, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("one_empty", b_dout_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
